// File: rtl/hex_display_bank.sv
// Multi-digit registered hex 7-segment driver with leading-zero blanking and
// per-digit blinking driven by an internal prescaler that resyncs on every load.
module hex_display_bank #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    BLANK_LZ,
    input  logic [NUM_DIGITS-1:0]   BLINK_EN,
    output logic [7*NUM_DIGITS-1:0] HEXOUT,
    output logic                    PHASE
);

    localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    // Table below is in active-low form; the mask flips it for active-high boards.
    localparam logic [6:0]      POL_MASK = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic [6:0]      SEG_OFF  = 7'h7F ^ POL_MASK;

    logic [4*NUM_DIGITS-1:0] val_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    phase_r;
    logic [7*NUM_DIGITS-1:0] hexout_r;
    logic [7*NUM_DIGITS-1:0] hex_next_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Value register: captures VALUE on load, otherwise holds.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val_r <= '0;
        end else if (LOAD) begin
            val_r <= VALUE;
        end else begin
            val_r <= val_r;
        end
    end

    // Blink prescaler; a load restarts it so fresh values begin visible.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (LOAD) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            phase_r <= phase_r;
        end
    end

    // Per-digit decode with blanking, scanned from the most significant digit down.
    always_comb begin
        logic       lz_run_s;
        logic       blank_s;
        logic [6:0] seg_s;
        hex_next_s = '0;
        lz_run_s   = 1'b1;
        blank_s    = 1'b0;
        seg_s      = 7'h7F;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run_s = lz_run_s & (val_r[4*i +: 4] == 4'h0);
            blank_s  = (BLANK_LZ & lz_run_s & (i != 0)) | (BLINK_EN[i] & phase_r);
            if (blank_s) begin
                seg_s = 7'h7F;
            end else begin
                seg_s = seg_decode(val_r[4*i +: 4]);
            end
            hex_next_s[7*i +: 7] = seg_s ^ POL_MASK;
        end
    end

    // Output register: every edge reloads the decoded pattern.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hexout_r <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            hexout_r <= hex_next_s;
        end
    end

    assign HEXOUT = hexout_r;
    assign PHASE  = phase_r;

endmodule

// File: tb/tb_hex_display_bank.sv
// Randomised self-checking bench for hex_display_bank: drives an active-low and
// an active-high instance from shared inputs and compares against a reference model.
module tb_hex_display_bank;

    localparam int ND  = 4;
    localparam int DIV = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load = 1'b0;
    logic [4*ND-1:0] value = '0;
    logic            blank_lz = 1'b0;
    logic [ND-1:0]   blink_en = '0;
    logic [7*ND-1:0] hexout_al;
    logic [7*ND-1:0] hexout_ah;
    logic            phase_al;
    logic            phase_ah;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: loaded value, edges since last resync, expected output.
    logic [15:0] m_val = '0;
    int          m_since = 0;
    logic [27:0] m_hex = 28'hFFFFFFF;

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(1)) dut_al (
        .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .BLANK_LZ(blank_lz),
        .BLINK_EN(blink_en), .HEXOUT(hexout_al), .PHASE(phase_al));

    hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(0)) dut_ah (
        .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .BLANK_LZ(blank_lz),
        .BLINK_EN(blink_en), .HEXOUT(hexout_ah), .PHASE(phase_ah));

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_phase();
        return ((m_since / DIV) % 2) == 1;
    endfunction

    function automatic logic [27:0] model_hex(input logic [15:0] v, input logic lz,
                                              input logic [3:0] ben, input logic ph);
        logic [27:0] res;
        res = '0;
        for (int d = 0; d < ND; d++) begin
            int  upper;
            int  nib;
            logic blank;
            upper = int'(v) >> (4 * d);
            nib   = upper % 16;
            blank = (lz && d > 0 && upper == 0) || (ben[d] && ph);
            res[7*d +: 7] = blank ? 7'h7F : seg_tab[nib];
        end
        return res;
    endfunction

    task automatic model_reset();
        m_val   = '0;
        m_since = 0;
        m_hex   = 28'hFFFFFFF;
    endtask

    task automatic tick();
        @(posedge clk);
        m_hex = model_hex(m_val, blank_lz, blink_en, model_phase());
        if (load) begin
            m_val   = value;
            m_since = 0;
        end else begin
            m_since++;
        end
        @(negedge clk);
        check_value("hexout_al", hexout_al, m_hex);
        check_value("hexout_ah", hexout_ah, ~m_hex);
        check_value("phase_al", {27'd0, phase_al}, {27'd0, model_phase()});
        check_value("phase_ah", {27'd0, phase_ah}, {27'd0, model_phase()});
    endtask

    task automatic reset_now(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_value({tag, "_al"}, hexout_al, 28'hFFFFFFF);
        check_value({tag, "_ah"}, hexout_ah, 28'h0000000);
        check_value({tag, "_phase"}, {27'd0, phase_al}, 28'd0);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_and_show(input logic [15:0] v, input logic lz, input logic [3:0] ben);
        load = 1'b1; value = v; blank_lz = lz; blink_en = ben;
        tick();
        load = 1'b0;
        tick();
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        reset_now("reset");

        load_and_show(16'h1234, 1'b0, 4'b0000);
        check_value("basic_1234", hexout_al, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        for (int k = 0; k < 3; k++) tick();
        check_value("hold_1234", hexout_al, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

        load_and_show(16'h00A0, 1'b1, 4'b0000);
        check_value("lz_00a0", hexout_al, {7'b1111111, 7'b1111111, 7'b0001000, 7'b1000000});
        load_and_show(16'h0000, 1'b1, 4'b0000);
        check_value("lz_0000", hexout_al, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
        load_and_show(16'h1005, 1'b1, 4'b0000);
        check_value("lz_1005", hexout_al, {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010});

        // Blinking on digit 0: four edges visible, four dark.
        load_and_show(16'h1234, 1'b0, 4'b0001);
        for (int k = 0; k < 16; k++) tick();

        // Wait for counter=3 with PHASE=1, then resync with a load.
        for (int k = 0; k < 16 && (m_since % 8) != 7; k++) tick();
        check_value("resync_setup", {27'd0, phase_al}, 28'd1);
        load = 1'b1; value = 16'h1234;
        tick();
        load = 1'b0;
        check_value("resync_phase0", {27'd0, phase_al}, 28'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_value("resync_hold", {27'd0, phase_al}, 28'd0);
        end
        tick();
        check_value("resync_toggle", {27'd0, phase_al}, 28'd1);

        // Active-high polarity with leading-zero blanking.
        load_and_show(16'h0008, 1'b1, 4'b0000);
        check_value("pol_0008", hexout_ah, 28'h000007F);

        // Reset mid-blink, then recovery shows a cleared value.
        load_and_show(16'hBEEF, 1'b0, 4'b1111);
        for (int k = 0; k < 5; k++) tick();
        reset_now("midreset");
        blink_en = '0;
        tick();
        check_value("recover_zero", hexout_al, {4{7'b1000000}});

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r        = $urandom;
            load     = ($urandom_range(0, 5) == 0);
            value    = 16'(r >> (4 * $urandom_range(0, 4)));
            if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 9) == 0) blink_en = 4'($urandom);
            tick();
            if ($urandom_range(0, 99) == 0) reset_now("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hex_display_bank.md
Name: hex_display_bank

Overview:
Parametrised multi-digit hexadecimal 7-segment display driver. It is the registered, multi-channel successor to the team's single-digit combinational hex decoder. It latches a packed NUM_DIGITS-nibble value on a load strobe and decodes every nibble to a 7-segment pattern. It adds optional leading-zero blanking and per-digit blinking from an internal prescaler, and drives the board HEX displays directly.

Parameters:
NUM_DIGITS, 4, number of hex digits/displays driven (1..8)
BLINK_DIV, 25000000, blink half-period in CLK cycles (>=1)
ACTIVE_LOW, 1, 1 = segment on is 0 (board default); 0 = segment on is 1

Ports:
CLK  input  1  system clock; all state changes on its rising edge
RST  input  1  asynchronous reset, active-high
LOAD  input  1  sampled on a CLK edge; when high, VALUE is captured
VALUE  input  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant)
BLANK_LZ  input  1  1 = suppress leading zero digits
BLINK_EN  input  NUM_DIGITS  per-digit blink enable; bit i = digit i
HEXOUT  output  7*NUM_DIGITS  segment outputs; [7i+6:7i] = digit i, bit 0 = seg a, bit 6 = seg g
PHASE  output  1  current blink phase; 1 = blinking digits dark

Behaviour:
- Reset (RST high, asynchronous, no clock needed):
  - value register = 0, blink counter = 0, PHASE = 0.
  - HEXOUT = all segments off: all 1s when ACTIVE_LOW=1, all 0s when ACTIVE_LOW=0.
- Value register: on a rising edge with LOAD=1, VAL_R <= VALUE. LOAD=0 holds VAL_R.
- Output register: HEXOUT is fully registered and recomputed every edge from VAL_R, BLANK_LZ, BLINK_EN and PHASE. No combinational path from inputs to HEXOUT.
- Latency: VALUE applied with LOAD at edge k is reflected on HEXOUT after edge k+1. BLANK_LZ and BLINK_EN changes take effect after one edge.
- Decode, active-low form, segments g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - ACTIVE_LOW=0 inverts every bit, including blank.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i>=1) is blank iff nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
  - Interior zeros (e.g. 0x1005) are shown.
- Blink prescaler:
  - Counter runs 0..BLINK_DIV-1 continuously.
  - On the edge where counter = BLINK_DIV-1: counter <= 0 and PHASE toggles.
  - BLINK_DIV=1 toggles PHASE every edge.
  - Counter runs regardless of BLINK_EN.
- Blink gating: digit i is blank when BLINK_EN[i]=1 and PHASE=1. Blanking is the OR of the leading-zero and blink conditions.
- Load resync: an edge with LOAD=1 also forces counter <= 0 and PHASE <= 0. A newly loaded value therefore starts in its visible phase. This takes priority over the terminal-count toggle on the same edge.
- LOAD held high: VALUE is recaptured every edge and the counter stays at 0, so blinking digits remain visible.
- Reset mid-operation: asynchronous clear as above. Normal operation resumes on the first edge after RST falls.
- Counter width: ceil(log2(BLINK_DIV)), minimum 1 bit. No overflow beyond BLINK_DIV-1.

Test Plan:
Bench config: NUM_DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1 unless noted.
- Reset: assert RST with no clock -> HEXOUT=28'hFFFFFFF, PHASE=0 immediately.
- Basic load: LOAD=1, VALUE=16'h1234, BLANK_LZ=0, BLINK_EN=0 -> after 2nd edge, digit3..0 = 1111001, 0100100, 0110000, 0011001; values hold with LOAD=0.
- Leading-zero blanking: BLANK_LZ=1.
  - VALUE=16'h00A0 -> digit3,2 = 1111111, digit1 = 0001000, digit0 = 1000000.
  - VALUE=16'h0000 -> digits 3..1 blank, digit0 = 1000000.
  - VALUE=16'h1005 -> all four digits shown.
- Blinking: BLINK_EN=4'b0001 after loading 16'h1234 -> PHASE toggles every 4 edges; digit0 alternates 0011001 / 1111111 in 4-cycle runs; digits 3..1 steady.
- Load resync: pulse LOAD on the edge where counter=3 and PHASE=1 -> PHASE=0 and counter=0 after that edge; the next toggle occurs 4 edges later.
- Polarity and reset recovery: ACTIVE_LOW=0, VALUE=16'h0008 -> digit0 = 1111111, other digits 0000000 with BLANK_LZ=1. Assert RST mid-blink -> HEXOUT=0 asynchronously and VAL_R=0.
